// File: rtl/mac_acc_pipe.sv
// Pipelined multiply-accumulate around a combinational single-precision fused
// multiply-add (Result = A + B*C), with an optional internal accumulator as addend.

module MAC32_top #(
    parameter int PARM_XLEN = 32,
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23,
    parameter int PARM_BIAS = 127
) (
    input  logic [PARM_XLEN-1:0] A_i,
    input  logic [PARM_XLEN-1:0] B_i,
    input  logic [PARM_XLEN-1:0] C_i,
    output logic [PARM_XLEN-1:0] Result_o
);
    // Subnormal inputs count as zero and tiny results flush to zero.
    // Any Inf/NaN input yields the canonical quiet NaN.
    // Rounding is round-to-nearest-even.
    localparam int MW   = PARM_MANT + 1;
    localparam int PW   = 2 * MW;
    localparam int GW   = MW + 2;
    localparam int FW   = PW + GW;
    localparam int SW   = FW + 1;
    localparam int EW   = PARM_EXP + 4;
    localparam int SHW  = $clog2(SW + 1);
    localparam int EMAX = (1 << PARM_EXP) - 1;
    localparam logic [EW-1:0]        FW_E   = EW'(FW);
    localparam logic signed [EW-1:0] EMAX_S = EW'(EMAX);

    logic [PARM_EXP-1:0]   exp_a, exp_b, exp_c;
    logic                  zero_a, zero_p, special;
    logic                  sign_a, sign_p, sign_big, sign_small, sign_res;
    logic [MW-1:0]         man_a, man_b, man_c;
    logic [PW-1:0]         prod;
    logic signed [EW-1:0]  exp_p, exp_as, exp_big, exp_res, exp_fin;
    logic [EW-1:0]         exp_diff;
    logic [SHW-1:0]        shift_amt, lz;
    logic                  p_big, eff_sub, big_ge, small_lost;
    logic [FW-1:0]         frame_p, frame_a, big_frame, small_frame, small_shift, small_aligned;
    logic [SW-1:0]         mag_sum, norm;
    logic [PARM_MANT-1:0]  mant;
    logic                  guard, sticky, round_up;
    logic [PARM_MANT:0]    mant_rnd;

    function automatic logic [SHW-1:0] count_lz(input logic [SW-1:0] v);
        logic [SHW-1:0] n;
        n = SHW'(SW);
        for (int i = 0; i < SW; i++) begin
            if (v[i]) n = SHW'(SW - 1 - i);
        end
        return n;
    endfunction

    assign exp_a   = A_i[PARM_XLEN-2 -: PARM_EXP];
    assign exp_b   = B_i[PARM_XLEN-2 -: PARM_EXP];
    assign exp_c   = C_i[PARM_XLEN-2 -: PARM_EXP];
    assign zero_a  = (exp_a == '0);
    assign zero_p  = (exp_b == '0) | (exp_c == '0);
    assign special = (exp_a == PARM_EXP'(EMAX)) | (exp_b == PARM_EXP'(EMAX)) | (exp_c == PARM_EXP'(EMAX));
    assign man_a   = zero_a ? '0 : {1'b1, A_i[PARM_MANT-1:0]};
    assign man_b   = (exp_b == '0) ? '0 : {1'b1, B_i[PARM_MANT-1:0]};
    assign man_c   = (exp_c == '0) ? '0 : {1'b1, C_i[PARM_MANT-1:0]};
    assign sign_a  = A_i[PARM_XLEN-1];
    assign sign_p  = B_i[PARM_XLEN-1] ^ C_i[PARM_XLEN-1];

    // Both operands sit in an FW-bit frame whose top bit weighs 2^(exp-bias).
    assign prod    = PW'(man_b) * PW'(man_c);
    assign exp_p   = EW'(exp_b) + EW'(exp_c) - EW'(PARM_BIAS) + EW'(1);
    assign exp_as  = EW'(exp_a);
    assign frame_p = {prod, {GW{1'b0}}};
    assign frame_a = {man_a, {(FW-MW){1'b0}}};

    assign p_big       = !zero_p && (zero_a || (exp_p >= exp_as));
    assign big_frame   = p_big ? frame_p : frame_a;
    assign small_frame = p_big ? frame_a : frame_p;
    assign exp_big     = p_big ? exp_p : exp_as;
    assign exp_diff    = p_big ? $unsigned(exp_p - exp_as) : $unsigned(exp_as - exp_p);
    assign sign_big    = p_big ? sign_p : sign_a;
    assign sign_small  = p_big ? sign_a : sign_p;
    assign shift_amt   = (exp_diff > FW_E) ? SHW'(FW) : exp_diff[SHW-1:0];

    assign small_shift   = small_frame >> shift_amt;
    assign small_lost    = |(small_frame & ~({FW{1'b1}} << shift_amt));
    assign small_aligned = {small_shift[FW-1:1], small_shift[0] | small_lost};

    assign eff_sub = sign_p ^ sign_a;
    assign big_ge  = (big_frame >= small_aligned);
    assign mag_sum = !eff_sub ? ({1'b0, big_frame} + {1'b0, small_aligned}) :
                     big_ge   ? ({1'b0, big_frame} - {1'b0, small_aligned}) :
                                ({1'b0, small_aligned} - {1'b0, big_frame});
    assign sign_res = (mag_sum == '0) ? (sign_p & sign_a) :
                      (eff_sub && !big_ge) ? sign_small : sign_big;

    assign lz       = count_lz(mag_sum);
    assign norm     = mag_sum << lz;
    assign exp_res  = exp_big + EW'(1) - EW'(lz);
    assign mant     = norm[SW-2 -: PARM_MANT];
    assign guard    = norm[SW-2-PARM_MANT];
    assign sticky   = |norm[SW-3-PARM_MANT:0];
    assign round_up = guard & (sticky | mant[0]);
    assign mant_rnd = {1'b0, mant} + (PARM_MANT+1)'(round_up);
    assign exp_fin  = exp_res + EW'(mant_rnd[PARM_MANT]);

    always_comb begin
        Result_o = {sign_res, exp_fin[PARM_EXP-1:0], mant_rnd[PARM_MANT-1:0]};
        if (special)
            Result_o = {1'b0, {PARM_EXP{1'b1}}, 1'b1, {(PARM_MANT-1){1'b0}}};
        else if (!norm[SW-1] || exp_fin <= '0)
            Result_o = {sign_res, {(PARM_XLEN-1){1'b0}}};
        else if (exp_fin >= EMAX_S)
            Result_o = {sign_res, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}};
    end
endmodule

module mac_acc_pipe #(
    parameter int PARM_XLEN   = 32,
    parameter int PARM_EXP    = 8,
    parameter int PARM_MANT   = 23,
    parameter int PARM_BIAS   = 127,
    parameter int PARM_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [PARM_XLEN-1:0] A_i,
    input  logic [PARM_XLEN-1:0] B_i,
    input  logic [PARM_XLEN-1:0] C_i,
    input  logic                 acc_mode_i,
    input  logic                 acc_clr_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PARM_XLEN-1:0] Result_o,
    output logic [PARM_XLEN-1:0] acc_o
);
    typedef enum logic {IDLE, ACC_BUSY} state_t;

    state_t               state_q, state_d;
    logic [PARM_XLEN-1:0] acc_q, addend, mac_result, final_data;
    logic [PARM_XLEN-1:0] stage_data  [PARM_STAGES];
    logic                 stage_valid [PARM_STAGES];
    logic                 stage_acc   [PARM_STAGES];
    logic                 advance, accept, final_valid, final_acc, load_acc;

    assign out_valid_o = stage_valid[PARM_STAGES-1];
    assign Result_o    = stage_data[PARM_STAGES-1];
    assign acc_o       = acc_q;
    assign advance     = ~out_valid_o | out_ready_i;
    assign accept      = in_valid_i & in_ready_o;
    assign addend      = acc_mode_i ? (acc_clr_i ? '0 : acc_q) : A_i;

    MAC32_top #(
        .PARM_XLEN (PARM_XLEN),
        .PARM_EXP  (PARM_EXP),
        .PARM_MANT (PARM_MANT),
        .PARM_BIAS (PARM_BIAS)
    ) u_mac (
        .A_i      (addend),
        .B_i      (B_i),
        .C_i      (C_i),
        .Result_o (mac_result)
    );

    // final_* is whatever the last stage loads on an advancing edge.
    generate
        if (PARM_STAGES == 1) begin : g_single
            assign final_valid = accept;
            assign final_acc   = acc_mode_i;
            assign final_data  = mac_result;
        end else begin : g_multi
            assign final_valid = stage_valid[PARM_STAGES-2];
            assign final_acc   = stage_acc[PARM_STAGES-2];
            assign final_data  = stage_data[PARM_STAGES-2];
        end
    endgenerate

    assign load_acc = advance & final_valid & final_acc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < PARM_STAGES; i++) begin
                stage_valid[i] <= 1'b0;
                stage_acc[i]   <= 1'b0;
                stage_data[i]  <= '0;
            end
        end else if (advance) begin
            stage_valid[0] <= accept;
            stage_acc[0]   <= accept & acc_mode_i;
            stage_data[0]  <= mac_result;
            for (int i = 1; i < PARM_STAGES; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                stage_acc[i]   <= stage_acc[i-1];
                stage_data[i]  <= stage_data[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            acc_q <= '0;
        else if (load_acc)
            acc_q <= final_data;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // ACC_BUSY holds off every beat until the pending accumulate lands.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept && acc_mode_i && PARM_STAGES > 1) state_d = ACC_BUSY;
            ACC_BUSY: if (load_acc) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o = rst_ni & advance & (state_q == IDLE);
    end
endmodule
